// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared types and helpers for the multiplier arbiter slice.
//   REQ_ID_W(n) : width of a requester index for n requesters (min 1)
//   word_t      : 32-bit operand / result word
//   tag_t       : in-flight op tag {valid, issuer id}, sized for up to MAX_NREQ requesters
package mul_arb_pkg;

    localparam int unsigned MAX_NREQ = 8;

    function automatic int unsigned REQ_ID_W(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned ID_W = REQ_ID_W(MAX_NREQ);

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant.
//   req       in  N   request vector
//   ptr       in  W   highest-priority index this cycle
//   grant     out N   one-hot grant, zero when no request
//   grant_idx out W   index of the granted requester (0 when none)
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned W = REQ_ID_W(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);

    int unsigned   idx;
    logic [W-1:0]  idx_w;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // Walk ptr, ptr+1, ... wrapping at N; first hit wins.
            idx = 32'(ptr) + k;
            if (idx >= N) idx = idx - N;
            idx_w = W'(idx);
            if (!found && req[idx_w]) begin
                found        = 1'b1;
                grant[idx_w] = 1'b1;
                grant_idx    = idx_w;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one pipelined 32-bit multiplier among NREQ requesters.
//   CLK, rst_n          clock (posedge) and async active-low reset
//   req_valid/a/b       per-requester operand pair and valid
//   req_ready           one-hot round-robin grant (handshake = valid & ready)
//   resp_valid/resp_c   one-hot single-cycle result strobe and low-32 product
//   mul_a/mul_b/mul_c   registered operands to, and result from, the external mul
//   busy                any op in flight in the tag pipeline
//   op_count            completed ops, wraps at 2^16
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0][31:0] req_a,
    input  logic [NREQ-1:0][31:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       resp_valid,
    output logic [31:0]           resp_c,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic [31:0]           mul_c,
    output logic                  busy,
    output logic [15:0]           op_count
);

    localparam int unsigned PW = REQ_ID_W(NREQ);

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_next;
    logic [PW-1:0]     grant_idx;
    logic [NREQ-1:0]   grant;
    logic              hs;
    tag_t [MUL_LAT:0]  tag_pipe;
    logic [NREQ-1:0]   resp_onehot;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grant is suppressed while reset is held so nobody sees a spurious handshake.
    assign req_ready = rst_n ? grant : '0;
    assign hs        = |(req_valid & req_ready);
    assign ptr_next  = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);

    always_comb begin
        resp_onehot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            resp_onehot[i] = (tag_pipe[MUL_LAT].id == ID_W'(i));
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned s = 0; s <= MUL_LAT; s++) begin
            busy = busy | tag_pipe[s].v;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            tag_pipe   <= '0;
            resp_valid <= '0;
            resp_c     <= '0;
            op_count   <= '0;
        end else begin
            // Operands hold when idle so the multiplier inputs do not toggle.
            if (hs) begin
                ptr   <= ptr_next;
                mul_a <= req_a[grant_idx];
                mul_b <= req_b[grant_idx];
            end
            tag_pipe[0].v  <= hs;
            tag_pipe[0].id <= hs ? ID_W'(grant_idx) : '0;
            for (int unsigned s = 1; s <= MUL_LAT; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
            // The last tag stage lines up with mul_c for the op it describes.
            if (tag_pipe[MUL_LAT].v) begin
                resp_valid <= resp_onehot;
                resp_c     <= mul_c;
                op_count   <= op_count + 16'd1;
            end else begin
                resp_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed and randomized checks of mul_arbiter with a 2-cycle mul model.
module tb_mul_arbiter;

    logic             CLK;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0][31:0] req_a;
    logic [3:0][31:0] req_b;
    logic [3:0]       req_ready;
    logic [3:0]       resp_valid;
    logic [31:0]      resp_c;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic [31:0]      mul_c;
    logic             busy;
    logic [15:0]      op_count;

    int checks;
    int errors;

    mul_arbiter #(.NREQ(4), .MUL_LAT(2)) dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_c     (resp_c),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_c      (mul_c),
        .busy       (busy),
        .op_count   (op_count)
    );

    // External multiplier: operands at A/B become correct at C two edges later.
    logic [31:0] mul_p1;
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            mul_p1 <= '0;
            mul_c  <= '0;
        end else begin
            mul_p1 <= mul_a * mul_b;
            mul_c  <= mul_p1;
        end
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: priority pointer, expected-response queue, completion count.
    typedef struct {
        int unsigned due;
        int unsigned id;
        logic [31:0] val;
    } exp_t;

    exp_t        q[$];
    int unsigned m_ptr;
    int unsigned m_cnt;
    int unsigned cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check grant, take the edge, check responses.
    task automatic step(input logic [3:0] v, input logic [3:0][31:0] a, input logic [3:0][31:0] b,
                        output logic [3:0] rdy, output logic [3:0] rv, output logic [31:0] rc);
        int          g;
        logic [63:0] full;
        logic [31:0] exp_rv;
        logic [31:0] exp_c;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        #1;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (int'(m_ptr) + k) % 4;
            if (g < 0 && v[i]) g = i;
        end
        rdy = req_ready;
        chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        @(posedge CLK);
        cyc++;
        if (g >= 0) begin
            full = 64'(a[g]) * 64'(b[g]);
            q.push_back('{due: cyc + 3, id: g, val: full[31:0]});
            m_ptr = (g + 1) % 4;
        end
        #1;
        exp_rv = '0;
        exp_c  = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_rv = 32'd1 << q[0].id;
            exp_c  = q[0].val;
            void'(q.pop_front());
            m_cnt++;
        end
        rv = resp_valid;
        rc = resp_c;
        chk("resp_valid", 32'(resp_valid), exp_rv);
        if (exp_rv != 0) chk("resp_c", resp_c, exp_c);
        chk("busy", 32'(busy), (q.size() != 0) ? 32'd1 : 32'd0);
        chk("op_count", 32'(op_count), m_cnt % 65536);
    endtask

    task automatic idle(input int n);
        logic [3:0]  r0;
        logic [3:0]  r1;
        logic [31:0] r2;
        repeat (n) step(4'b0000, '0, '0, r0, r1, r2);
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #1;
        q.delete();
        m_ptr = 0;
        m_cnt = 0;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_c", resp_c, 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_mul_b", mul_b, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        repeat (n) @(posedge CLK);
        #1;
        chk("rst_hold_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
    endtask

    logic [3:0]       rdy;
    logic [3:0]       rv;
    logic [31:0]      rc;
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [31:0]      seq_c[$];
    logic [3:0]       seq_v[$];

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        m_ptr     = 0;
        m_cnt     = 0;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;

        // Reset held for four cycles with every requester asking.
        #2;
        do_reset(4);

        // Single op from requester 2.
        a = '0; b = '0;
        a[2] = 32'd7; b[2] = 32'd9;
        step(4'b0100, a, b, rdy, rv, rc);
        chk("single_ready", 32'(rdy), 32'b0100);
        chk("single_busy_e0", 32'(busy), 32'd1);
        idle(1);
        chk("single_busy_e1", 32'(busy), 32'd1);
        idle(1);
        chk("single_busy_e2", 32'(busy), 32'd1);
        step(4'b0000, '0, '0, rdy, rv, rc);
        chk("single_resp_valid", 32'(rv), 32'b0100);
        chk("single_resp_c", rc, 32'd63);

        // Full contention: strict rotation and back-to-back results.
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            a[i] = 32'(i + 1);
            b[i] = 32'd10;
        end
        seq_c.delete();
        seq_v.delete();
        for (int k = 0; k < 8; k++) begin
            step(4'hF, a, b, rdy, rv, rc);
            chk("contend_grant", 32'(rdy), 32'd1 << (k % 4));
            if (rv != 0) begin seq_v.push_back(rv); seq_c.push_back(rc); end
        end
        for (int k = 0; k < 3; k++) begin
            step(4'h0, a, b, rdy, rv, rc);
            if (rv != 0) begin seq_v.push_back(rv); seq_c.push_back(rc); end
        end
        chk("contend_nresp", 32'(seq_c.size()), 32'd8);
        for (int k = 0; k < seq_c.size() && k < 8; k++) begin
            chk("contend_resp_c", seq_c[k], 32'(((k % 4) + 1) * 10));
            chk("contend_resp_id", 32'(seq_v[k]), 32'd1 << (k % 4));
        end
        chk("contend_op_count", 32'(op_count), 32'd8);

        // Rotation between requesters 1 and 3 from a fresh pointer.
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            step(4'b1010, a, b, rdy, rv, rc);
            chk("rotate_grant", 32'(rdy), (k % 2 == 0) ? 32'b0010 : 32'b1000);
        end
        idle(3);

        // Truncating products.
        a = '0; b = '0;
        a[0] = 32'hFFFF_FFFF; b[0] = 32'd2;
        step(4'b0001, a, b, rdy, rv, rc);
        a[0] = 32'h0001_0000; b[0] = 32'h0001_0000;
        step(4'b0001, a, b, rdy, rv, rc);
        idle(1);
        step(4'b0000, '0, '0, rdy, rv, rc);
        chk("ovf_resp_c0", rc, 32'hFFFF_FFFE);
        step(4'b0000, '0, '0, rdy, rv, rc);
        chk("ovf_valid1", 32'(rv), 32'b0001);
        chk("ovf_resp_c1", rc, 32'd0);

        // Reset with three ops in flight: all are flushed.
        do_reset(1);
        a[0] = 32'd3; b[0] = 32'd5;
        step(4'b0001, a, b, rdy, rv, rc);
        step(4'b0001, a, b, rdy, rv, rc);
        step(4'b0001, a, b, rdy, rv, rc);
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            step(4'b0000, '0, '0, rdy, rv, rc);
            chk("flush_resp_valid", 32'(rv), 32'd0);
        end
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_op_count", 32'(op_count), 32'd0);

        // 1..10 x 1..10 sweep through requester 0.
        do_reset(1);
        for (int x = 1; x <= 10; x++) begin
            for (int y = 1; y <= 10; y++) begin
                a = '0; b = '0;
                a[0] = 32'(x); b[0] = 32'(y);
                step(4'b0001, a, b, rdy, rv, rc);
            end
        end
        idle(3);
        chk("sweep_op_count", 32'(op_count), 32'd100);

        // Random traffic against the model.
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 4; i++) begin
                a[i] = $urandom;
                b[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            end
            step(4'($urandom_range(0, 15)), a, b, rdy, rv, rc);
        end
        idle(4);
        chk("random_drained", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
